// File: rtl/aes_in_assembler.sv
// aes_in_assembler
//   Collects WORD_S-bit words from a valid/ready stream into a full AES key or
//   plaintext block, then starts one aes_top encryption and waits for it to
//   finish. The first word of a group chooses its type through in_key.
//   Words are packed big-endian: word 0 lands in the most significant bits.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   in_data       input word
//   in_key        1 = key group, 0 = plaintext group (read on word 0 only)
//   in_valid      in_data/in_key valid
//   in_ready      a word is accepted when in_valid & in_ready at a rising edge
//   en            one-cycle start pulse to aes_top
//   aes_key       current key (bit 0 = MSB)
//   aes_plaintext current block (bit 0 = MSB)
//   en_o          aes_top completion pulse
//   key_valid     a complete key is held
//   busy          a block has been issued and has not yet completed
//   key_err       one-cycle pulse: plaintext group completed with no key
module aes_in_assembler #(
    parameter int WORD_S = 32,
    parameter int KEY_S  = 128,
    parameter int BLK_S  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_S-1:0] in_data,
    input  logic              in_key,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              en,
    output logic [0:KEY_S-1]  aes_key,
    output logic [0:BLK_S-1]  aes_plaintext,
    input  logic              en_o,
    output logic              key_valid,
    output logic              busy,
    output logic              key_err
);

    localparam int NK   = KEY_S / WORD_S;
    localparam int NW   = BLK_S / WORD_S;
    localparam int MAXW = (NK > NW) ? NK : NW;
    localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

    localparam logic [CW-1:0] LAST_KEY = CW'(NK - 1);
    localparam logic [CW-1:0] LAST_PT  = CW'(NW - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_PT,
        ISSUE,
        WAIT
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [0:KEY_S-1] key_shadow;
    logic [0:BLK_S-1] pt_shadow;

    logic             hs;
    logic             grp_key;
    logic             last;
    logic [0:KEY_S-1] key_next;
    logic [0:BLK_S-1] pt_next;

    // Ready only in the loading states; forced low while reset is held so
    // nothing is accepted until the first cycle after release.
    assign in_ready = ~reset & ((state == IDLE) | (state == LOAD_KEY) | (state == LOAD_PT));
    assign hs       = in_valid & in_ready;

    // In IDLE the group type comes from the current word; afterwards it is
    // implied by the loading state, so in_key on later words is ignored.
    assign grp_key = (state == IDLE) ? in_key : (state == LOAD_KEY);
    assign last    = grp_key ? (cnt == LAST_KEY) : (cnt == LAST_PT);

    // Shadow contents with the incoming word merged in at the counter
    // position; used both for staging and for the final copy on completion.
    always_comb begin
        key_next = key_shadow;
        pt_next  = pt_shadow;
        key_next[int'(cnt)*WORD_S +: WORD_S] = in_data;
        pt_next[int'(cnt)*WORD_S +: WORD_S]  = in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            en            <= 1'b0;
            key_err       <= 1'b0;
            busy          <= 1'b0;
            key_valid     <= 1'b0;
            aes_key       <= '0;
            aes_plaintext <= '0;
            key_shadow    <= '0;
            pt_shadow     <= '0;
        end else begin
            en      <= 1'b0;
            key_err <= 1'b0;
            case (state)
                IDLE, LOAD_KEY, LOAD_PT: begin
                    if (hs) begin
                        if (grp_key) key_shadow <= key_next;
                        else         pt_shadow  <= pt_next;

                        if (last) begin
                            cnt <= '0;
                            if (grp_key) begin
                                // Key becomes visible only as a whole group.
                                aes_key   <= key_next;
                                key_valid <= 1'b1;
                                state     <= IDLE;
                            end else if (key_valid) begin
                                aes_plaintext <= pt_next;
                                en            <= 1'b1;
                                busy          <= 1'b1;
                                state         <= ISSUE;
                            end else begin
                                // No key yet: drop the block and flag it.
                                key_err <= 1'b1;
                                state   <= IDLE;
                            end
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= grp_key ? LOAD_KEY : LOAD_PT;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // aes_key/aes_plaintext are frozen here since no input is
                    // accepted until the cycle after en_o.
                    if (en_o) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_in_assembler.sv
module tb_aes_in_assembler;

    localparam logic [127:0] K1 = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] P1 = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] K2 = 128'h00112233445566778899AABBCCDDEEFF;

    logic         clk;
    logic         reset;
    logic [31:0]  in_data;
    logic         in_key;
    logic         in_valid;
    logic         in_ready;
    logic         en;
    logic [0:127] aes_key;
    logic [0:127] aes_plaintext;
    logic         en_o;
    logic         key_valid;
    logic         busy;
    logic         key_err;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;
    int en_base;

    aes_in_assembler #(.WORD_S(32), .KEY_S(128), .BLK_S(128)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_key        (in_key),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .en            (en),
        .aes_key       (aes_key),
        .aes_plaintext (aes_plaintext),
        .en_o          (en_o),
        .key_valid     (key_valid),
        .busy          (busy),
        .key_err       (key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count en-high cycles, sampled away from the active edge.
    always @(negedge clk) if (en) en_cnt++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one word for exactly one rising edge; returns on the next negedge.
    task automatic send_word(input logic [31:0] d, input logic k);
        in_data  = d;
        in_key   = k;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    // Sends a 4-word group, word 0 first. Later words carry the opposite
    // in_key value, which must be ignored. gap inserts an idle cycle between words.
    task automatic send_group(input logic [127:0] v, input logic k, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_word(v[127-32*i -: 32], (i == 0) ? k : ~k);
            if (gap && i < 3) idle_cycle();
        end
    endtask

    task automatic pulse_en_o();
        en_o = 1'b1;
        @(negedge clk);
        en_o = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = '0;
        in_key   = 1'b0;
        in_valid = 1'b0;
        en_o     = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_en", 128'(en), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_key_valid", 128'(key_valid), 128'd0);
        chk("rst_key_err", 128'(key_err), 128'd0);
        chk("rst_aes_key", aes_key, 128'd0);
        chk("rst_aes_pt", aes_plaintext, 128'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 128'(in_ready), 128'd1);

        // en_o in IDLE is ignored
        pulse_en_o();
        chk("idle_eno_busy", 128'(busy), 128'd0);
        chk("idle_eno_ready", 128'(in_ready), 128'd1);
        chk("idle_eno_en", 128'(en), 128'd0);

        // Plaintext with no key: key_err for one cycle, block dropped
        send_group(P1, 1'b0, 1'b0);
        chk("nokey_err", 128'(key_err), 128'd1);
        chk("nokey_en", 128'(en), 128'd0);
        chk("nokey_ready", 128'(in_ready), 128'd1);
        idle_cycle();
        chk("nokey_err_pulse", 128'(key_err), 128'd0);
        chk("nokey_pt", aes_plaintext, 128'd0);
        chk("nokey_encnt", 128'(en_cnt), 128'd0);

        // Key load
        send_group(K1, 1'b1, 1'b0);
        chk("k1_valid", 128'(key_valid), 128'd1);
        chk("k1_key", aes_key, K1);
        chk("k1_en", 128'(en), 128'd0);
        idle_cycle();
        chk("k1_encnt", 128'(en_cnt), 128'd0);

        // Plaintext with an en_o pulse while mid-group in LOAD_PT
        send_word(P1[127:96], 1'b0);
        send_word(P1[95:64], 1'b1);
        pulse_en_o();
        chk("ldpt_eno_busy", 128'(busy), 128'd0);
        chk("ldpt_eno_ready", 128'(in_ready), 128'd1);
        chk("ldpt_eno_en", 128'(en), 128'd0);
        send_word(P1[63:32], 1'b1);
        send_word(P1[31:0], 1'b1);
        chk("p1_en", 128'(en), 128'd1);
        chk("p1_pt", aes_plaintext, P1);
        chk("p1_busy", 128'(busy), 128'd1);
        chk("p1_ready_issue", 128'(in_ready), 128'd0);
        idle_cycle();
        chk("p1_en_pulse", 128'(en), 128'd0);
        chk("p1_ready_wait", 128'(in_ready), 128'd0);
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        in_key   = 1'b1;
        idle_cycle();
        idle_cycle();
        in_valid = 1'b0;
        chk("wait_busy", 128'(busy), 128'd1);
        chk("wait_key_stable", aes_key, K1);
        chk("wait_pt_stable", aes_plaintext, P1);
        pulse_en_o();
        chk("done_ready", 128'(in_ready), 128'd1);
        chk("done_busy", 128'(busy), 128'd0);
        chk("done_pt_stable", aes_plaintext, P1);
        chk("p1_encnt", 128'(en_cnt), 128'd1);

        // Key replacement with stalls; no partial update of aes_key
        send_word(K2[127:96], 1'b1);
        idle_cycle();
        send_word(K2[95:64], 1'b0);
        chk("k2_mid_valid", 128'(key_valid), 128'd1);
        chk("k2_mid_key", aes_key, K1);
        idle_cycle();
        send_word(K2[63:32], 1'b0);
        idle_cycle();
        send_word(K2[31:0], 1'b0);
        chk("k2_key", aes_key, K2);
        chk("k2_valid", 128'(key_valid), 128'd1);

        // Toggled in_valid for key and plaintext groups
        en_base = en_cnt;
        send_group(K1, 1'b1, 1'b1);
        chk("tog_key", aes_key, K1);
        idle_cycle();
        send_group(P1, 1'b0, 1'b1);
        chk("tog_en", 128'(en), 128'd1);
        chk("tog_pt", aes_plaintext, P1);
        idle_cycle();
        idle_cycle();
        chk("tog_encnt", 128'(en_cnt - en_base), 128'd1);

        // Reset while in WAIT, then a stray en_o
        reset = 1'b1;
        #1;
        chk("wrst_key", aes_key, 128'd0);
        chk("wrst_pt", aes_plaintext, 128'd0);
        chk("wrst_busy", 128'(busy), 128'd0);
        chk("wrst_valid", 128'(key_valid), 128'd0);
        chk("wrst_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        en_base = en_cnt;
        pulse_en_o();
        chk("wrst_eno_ready", 128'(in_ready), 128'd1);
        chk("wrst_eno_busy", 128'(busy), 128'd0);
        chk("wrst_eno_valid", 128'(key_valid), 128'd0);

        // Key must be reloaded before another block can issue
        send_group(P1, 1'b0, 1'b0);
        chk("wrst_key_err", 128'(key_err), 128'd1);
        chk("wrst_no_en", 128'(en), 128'd0);
        idle_cycle();
        chk("wrst_encnt", 128'(en_cnt - en_base), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
